wheel_pulse_conditioner: RTL and testbench

//  Front end for the wheel hall sensor. Synchronises and debounces the raw

---
 rtl/wheel_pulse_conditioner_pkg.sv | 9 +
 rtl/wheel_pulse_conditioner_if.sv | 15 +
 rtl/wheel_pulse_conditioner_hall_debounce.sv | 38 +++
 rtl/wheel_pulse_conditioner.sv | 88 ++++++++
 tb/tb_wheel_pulse_conditioner.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/wheel_pulse_conditioner_pkg.sv
// Shared constants and FSM state type for the wheel hall-sensor front end.
// Pure declarations, no timing; no flow control.
package wheel_pkg;
  localparam int DEBOUNCE_CYC_DEF = 16;
  localparam int PERIOD_W_DEF     = 16;
  localparam int STALL_CYC_DEF    = 50000;

  typedef enum logic [0:0] {ST_IDLE, ST_MEASURE} wheel_state_t;
endpackage

// File: rtl/wheel_pulse_conditioner_if.sv
// Hall input and conditioned tick/period/count outputs of the wheel front end.
// master = sensor side / consumer, slave = conditioner.
interface wheel_pulse_conditioner_if #(parameter int PERIOD_W = 16);
  logic                hall_in;
  logic                rev_tick;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic [15:0]         rev_count;
  logic                stalled;

  modport master (output hall_in,
                  input  rev_tick, period, period_valid, rev_count, stalled);
  modport slave  (input  hall_in,
                  output rev_tick, period, period_valid, rev_count, stalled);
endinterface

// File: rtl/wheel_pulse_conditioner_hall_debounce.sv
// Two-flop synchroniser plus debounce filter; level follows after 2+DEBOUNCE_CYC cycles.
// No backpressure: free-running on every clk.
module hall_debounce
  import wheel_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic hall_in,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= hall_in;
      sync2 <= sync1;
      // Any cycle agreeing with the accepted level restarts the run.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/wheel_pulse_conditioner.sv
// Wheel pulse conditioner: one tick per revolution, revolution period and count.
// Tick 2+DEBOUNCE_CYC+1 cycles after a hall rise; no backpressure. Stall detection under WHEEL_STALL_DETECT_EN.
module wheel_pulse_conditioner
  import wheel_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int PERIOD_W     = PERIOD_W_DEF,
  parameter int STALL_CYC    = STALL_CYC_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  wheel_pulse_conditioner_if.slave    bus
);
  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

  if (STALL_CYC >= (1 << PERIOD_W)) begin : g_bad_stall
    $error("STALL_CYC must fit in PERIOD_W bits");
  end

  logic                level, level_d, tick;
  wheel_state_t        state;
  logic [PERIOD_W-1:0] cnt, period_q;
  logic [15:0]         rev_q;
  logic                rev_tick_q, pv_q;

  hall_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
    .clk     (clk),
    .reset   (reset),
    .hall_in (bus.hall_in),
    .level   (level)
  );

  assign tick = level & ~level_d;

`ifdef WHEEL_STALL_DETECT_EN
  localparam logic [PERIOD_W-1:0] STALL_CNT = PERIOD_W'(STALL_CYC);
  logic stalled_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      level_d    <= 1'b0;
      rev_tick_q <= 1'b0;
      pv_q       <= 1'b0;
      state      <= ST_IDLE;
      cnt        <= '0;
      period_q   <= '0;
      rev_q      <= '0;
`ifdef WHEEL_STALL_DETECT_EN
      stalled_q  <= 1'b0;
`endif
    end else begin
      level_d    <= level;
      rev_tick_q <= tick;
      pv_q       <= 1'b0;
      if (tick) begin
        rev_q <= rev_q + 16'd1;
        // The first tick after IDLE only sets the reference point.
        if (state == ST_MEASURE) begin
          period_q <= cnt;
          pv_q     <= 1'b1;
        end
        state <= ST_MEASURE;
        cnt   <= CNT_ONE;
`ifdef WHEEL_STALL_DETECT_EN
        stalled_q <= 1'b0;
      end else if (state == ST_MEASURE && cnt == STALL_CNT) begin
        state     <= ST_IDLE;
        period_q  <= '0;
        stalled_q <= 1'b1;
`endif
      end else if (state == ST_MEASURE && cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  assign bus.rev_tick     = rev_tick_q;
  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
  assign bus.rev_count    = rev_q;
`ifdef WHEEL_STALL_DETECT_EN
  assign bus.stalled      = stalled_q;
`else
  assign bus.stalled      = 1'b0;
`endif
endmodule

// File: tb/tb_wheel_pulse_conditioner.sv
// Bench for wheel_pulse_conditioner: a 16-bit and an 8-bit period instance share one hall input,
// checked every cycle against a window/timestamp model plus directed literal expectations.
module tb_wheel_pulse_conditioner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hall = 1'b0;

  always #5 clk = ~clk;

  wheel_pulse_conditioner_if #(.PERIOD_W(16)) bus16 ();
  wheel_pulse_conditioner_if #(.PERIOD_W(8))  bus8 ();
  assign bus16.hall_in = hall;
  assign bus8.hall_in  = hall;

  wheel_pulse_conditioner #(.DEBOUNCE_CYC(16), .PERIOD_W(16), .STALL_CYC(50000)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16.slave));
  wheel_pulse_conditioner #(.DEBOUNCE_CYC(16), .PERIOD_W(8), .STALL_CYC(200)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8.slave));

  int tests = 0;
  int failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      if (failed <= 30)
        $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  // Model: hall samples per edge; filtered level flips when the 16 synchronised
  // samples (hall seen 2..17 edges ago) all disagree with it.
  int          ecnt = 0;
  bit          hq[$];
  bit          m_filt, m_pend;
  bit          e_tick;
  bit          e_pv[2], e_st[2], m_ref[2];
  int          m_last[2];
  logic [15:0] e_per[2];
  logic [15:0] e_cnt;

  function automatic int pmax(input int k);
    return (k == 0) ? 65535 : 255;
  endfunction
  function automatic int stall_of(input int k);
    return (k == 0) ? 50000 : 200;
  endfunction

  always @(posedge clk) begin
    bit all_diff;
    ecnt++;
    if (reset) begin
      hq.delete();
      repeat (18) hq.push_back(1'b0);
      m_filt = 0; m_pend = 0; e_tick = 0; e_cnt = 0;
      for (int k = 0; k < 2; k++) begin
        e_pv[k] = 0; e_st[k] = 0; m_ref[k] = 0; m_last[k] = 0; e_per[k] = 0;
      end
    end else begin
      hq.push_back(hall);
      void'(hq.pop_front());
      e_tick = m_pend;
      if (e_tick) e_cnt = e_cnt + 16'd1;
      for (int k = 0; k < 2; k++) begin
        e_pv[k] = 0;
        if (e_tick) begin
          if (m_ref[k]) begin
            e_per[k] = 16'((ecnt - m_last[k]) > pmax(k) ? pmax(k) : (ecnt - m_last[k]));
            e_pv[k]  = 1;
          end
          m_ref[k] = 1; m_last[k] = ecnt; e_st[k] = 0;
        end
`ifdef WHEEL_STALL_DETECT_EN
        else if (m_ref[k] && (ecnt - m_last[k]) == stall_of(k)) begin
          m_ref[k] = 0; e_per[k] = 0; e_st[k] = 1;
        end
`endif
      end
      all_diff = 1;
      for (int i = 0; i < 16; i++) if (hq[i] == m_filt) all_diff = 0;
      m_pend = all_diff && !m_filt;
      if (all_diff) m_filt = !m_filt;
    end
  end

  // Per-cycle comparison and event bookkeeping for the directed checks.
  int n_tick = 0, tick_edge = 0, n_pv16 = 0, n_pv8 = 0, last_per16 = 0, last_per8 = 0;
  always @(negedge clk) begin
    if (ecnt > 0) begin
      chk("rev_tick16", 32'(bus16.rev_tick), 32'(e_tick));
      chk("rev_tick8", 32'(bus8.rev_tick), 32'(e_tick));
      chk("pv16", 32'(bus16.period_valid), 32'(e_pv[0]));
      chk("pv8", 32'(bus8.period_valid), 32'(e_pv[1]));
      chk("period16", 32'(bus16.period), 32'(e_per[0]));
      chk("period8", 32'(bus8.period), 32'(e_per[1]));
      chk("rev_count16", 32'(bus16.rev_count), 32'(e_cnt));
      chk("rev_count8", 32'(bus8.rev_count), 32'(e_cnt));
      chk("stalled16", 32'(bus16.stalled), 32'(e_st[0]));
      chk("stalled8", 32'(bus8.stalled), 32'(e_st[1]));
    end
    if (bus16.rev_tick === 1'b1) begin n_tick++; tick_edge = ecnt; end
    if (bus16.period_valid === 1'b1) begin n_pv16++; last_per16 = int'(bus16.period); end
    if (bus8.period_valid === 1'b1) begin n_pv8++; last_per8 = int'(bus8.period); end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
    #2;
  endtask

  task automatic do_reset(input int k);
    reset = 1'b1;
    cyc(k);
    reset = 1'b0;
  endtask

  initial begin
    int t0, ticks0, pv0, pv80;
    cyc(3);
    reset = 1'b0;
    cyc(5);
    chk("reset_rev_count", 32'(bus16.rev_count), 32'd0);
    chk("reset_period", 32'(bus16.period), 32'd0);
    chk("reset_tick", 32'(bus16.rev_tick), 32'd0);

    // Clean pulse
    t0 = ecnt; ticks0 = n_tick; pv0 = n_pv16;
    hall = 1'b1; cyc(40);
    hall = 1'b0; cyc(40);
    chk("t1_ticks", 32'(n_tick - ticks0), 32'd1);
    chk("t1_latency", 32'(tick_edge - t0), 32'd19);
    chk("t1_rev_count", 32'(bus16.rev_count), 32'd1);
    chk("t1_no_pv", 32'(n_pv16 - pv0), 32'd0);

    // Bounce: short glitches are rejected, the stable high ticks once
    ticks0 = n_tick;
    for (int g = 0; g < 5; g++) begin
      hall = 1'b1; cyc(3);
      hall = 1'b0; cyc(3);
    end
    cyc(20);
    chk("t2_glitch_no_tick", 32'(n_tick - ticks0), 32'd0);
    t0 = ecnt;
    hall = 1'b1; cyc(40);
    hall = 1'b0; cyc(40);
    chk("t2_ticks", 32'(n_tick - ticks0), 32'd1);
    chk("t2_latency", 32'(tick_edge - t0), 32'd19);
    chk("t2_rev_count", 32'(bus16.rev_count), 32'd2);

    // Period: rises 1000 cycles apart
    do_reset(2); cyc(5);
    pv0 = n_pv16; pv80 = n_pv8;
    for (int r = 0; r < 3; r++) begin
      hall = 1'b1; cyc(40);
      hall = 1'b0; cyc(960);
    end
    chk("t3_pv_count", 32'(n_pv16 - pv0), 32'd2);
    chk("t3_period", 32'(last_per16), 32'd1000);
    chk("t3_rev_count", 32'(bus16.rev_count), 32'd3);

`ifndef WHEEL_STALL_DETECT_EN
    // Saturation on the 8-bit instance: rises 400 apart
    do_reset(2); cyc(5);
    pv0 = n_pv16; pv80 = n_pv8;
    for (int r = 0; r < 2; r++) begin
      hall = 1'b1; cyc(40);
      hall = 1'b0; cyc(360);
    end
    chk("t4_pv8_count", 32'(n_pv8 - pv80), 32'd1);
    chk("t4_period8_sat", 32'(last_per8), 32'd255);
    chk("t4_period16", 32'(last_per16), 32'd400);
`endif

    // Reset mid-debounce
    hall = 1'b1; cyc(10);
    reset = 1'b1; hall = 1'b0; cyc(2);
    chk("t6_rev_count", 32'(bus16.rev_count), 32'd0);
    chk("t6_period", 32'(bus16.period), 32'd0);
    chk("t6_period8", 32'(bus8.period), 32'd0);
    reset = 1'b0;
    ticks0 = n_tick;
    cyc(30);
    chk("t6_no_tick", 32'(n_tick - ticks0), 32'd0);
    t0 = ecnt;
    hall = 1'b1; cyc(40);
    hall = 1'b0; cyc(40);
    chk("t6_ticks", 32'(n_tick - ticks0), 32'd1);
    chk("t6_latency", 32'(tick_edge - t0), 32'd19);
    chk("t6_rev_count", 32'(bus16.rev_count), 32'd1);

`ifdef WHEEL_STALL_DETECT_EN
    // Stall on the 8-bit instance (STALL_CYC=200)
    cyc(200);
    chk("t5_stalled", 32'(bus8.stalled), 32'd1);
    chk("t5_period0", 32'(bus8.period), 32'd0);
    pv80 = n_pv8;
    hall = 1'b1; cyc(40);
    hall = 1'b0; cyc(40);
    chk("t5_stall_cleared", 32'(bus8.stalled), 32'd0);
    chk("t5_no_pv", 32'(n_pv8 - pv80), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
